// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Active-low common-anode 7-segment constants and the BCD to
//               {a..g} encoder shared by the counter/display blocks.
//               Bit order of every pattern is {a,b,c,d,e,f,g}.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Entry n is the pattern for digit n (entry 9 in the top slice).
  localparam logic [9:0][6:0] SEG_ENC = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Non-BCD nibbles show a dash so a corrupted digit is visible on the panel.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return SEG_DASH;
    end
    return SEG_ENC[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_updown_counter_7seg_mux_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One BCD digit of the up/down counter.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   en           : step this digit (already qualified by lower carries)
//   up           : 1 = increment, 0 = decrement
//   load         : synchronous load, overrides en
//   load_val     : value to load; nibbles above 9 load as 0
//   q            : current digit value
//   carry_out    : digit would wrap on the next step in the current direction
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
  import seg7_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val > 4'd9) ? 4'd0 : load_val;
    end else if (en) begin
      if (up) begin
        q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = (up && (q_q == 4'd9)) || (!up && (q_q == 4'd0));

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter_7seg_mux
// Description : NDIGITS-digit BCD up/down counter with load, terminal count
//               and sticky overflow, driving a time-multiplexed common-anode
//               7-segment display.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   CE, UP       : count enable and direction
//   LOAD         : synchronous load of LOAD_VAL (wins over CE)
//   CLR_OVF      : clears OVF (a wrap in the same cycle wins)
//   COUNT        : registered BCD count, digit 0 in [3:0]
//   TC           : this edge will wrap the counter
//   OVF          : sticky wrap flag
//   AN           : active-low digit select
//   a..g         : active-low segments, registered
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_counter_7seg_mux
  import seg7_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 4,
  parameter bit SHOW_OVF = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CE,
  input  logic                 UP,
  input  logic                 LOAD,
  input  logic [4*NDIGITS-1:0] LOAD_VAL,
  input  logic                 CLR_OVF,
  output logic [4*NDIGITS-1:0] COUNT,
  output logic                 TC,
  output logic                 OVF,
  output logic [NDIGITS-1:0]   AN,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 e,
  output logic                 f,
  output logic                 g
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (NDIGITS  > 1) ? $clog2(NDIGITS)  : 1;

  logic [3:0]         digit_q [NDIGITS];
  logic [NDIGITS-1:0] carry;
  logic [NDIGITS-1:0] en;

  // Digit i steps only when every lower digit is about to wrap.
  assign en[0] = CE;

  generate
    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
      if (i > 0) begin : g_chain
        assign en[i] = en[i-1] & carry[i-1];
      end
      bcd_digit u_digit (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .en        (en[i]),
        .up        (UP),
        .load      (LOAD),
        .load_val  (LOAD_VAL[4*i +: 4]),
        .q         (digit_q[i]),
        .carry_out (carry[i])
      );
      assign COUNT[4*i +: 4] = digit_q[i];
    end
  endgenerate

  // All digits at their wrap value in the current direction means wrap.
  assign TC = CE & ~LOAD & (&carry);

  logic              ovf_q,  ovf_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DIG_W-1:0]  idx_q,  idx_d;
  logic [NDIGITS-1:0] an_q,  an_d;
  logic [6:0]        seg_q,  seg_d;

  always_comb begin
    ovf_d  = ovf_q;
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    an_d   = ~(NDIGITS'(1) << idx_q);
    seg_d  = bcd_to_seg(digit_q[idx_q]);

    if (TC) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end

    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == DIG_W'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    if (SHOW_OVF && ovf_q) begin
      seg_d = SEG_DASH;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q  <= 1'b0;
      scan_q <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      ovf_q  <= ovf_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign OVF = ovf_q;
  assign AN  = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter_7seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_updown_counter_7seg_mux
// Description : Self-checking bench: decimal-arithmetic reference model,
//               per-cycle compare, directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter_7seg_mux;

  localparam int ND   = 4;
  localparam int SDIV = 3;
  localparam int MAXV = 9999;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0, up = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [4*ND-1:0] load_val = '0;
  logic [4*ND-1:0] count;
  logic          tc, ovf;
  logic [ND-1:0] an;
  logic          sa, sb, sc, sd, se, sf, sg;
  logic [6:0]    seg;

  assign seg = {sa, sb, sc, sd, se, sf, sg};

  always #5 clk = ~clk;

  bcd_updown_counter_7seg_mux #(
    .NDIGITS (ND),
    .SCAN_DIV(SDIV),
    .SHOW_OVF(1'b1)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .CE      (ce),
    .UP      (up),
    .LOAD    (load),
    .LOAD_VAL(load_val),
    .CLR_OVF (clr_ovf),
    .COUNT   (count),
    .TC      (tc),
    .OVF     (ovf),
    .AN      (an),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  int          m_count = 0;
  bit          m_ovf = 1'b0;
  int          m_edge = 0;
  logic [ND-1:0] m_an = '1;
  logic [6:0]  m_seg = 7'b1111111;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int dgt);
    case (dgt)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int load_dec(input logic [4*ND-1:0] lv);
    int r = 0;
    for (int i = 0; i < ND; i++)
      if (lv[4*i +: 4] <= 4'd9) r += int'(lv[4*i +: 4]) * pow10(i);
    return r;
  endfunction

  function automatic bit model_tc();
    return ce && !load && (up ? (m_count == MAXV) : (m_count == 0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_ovf   <= 1'b0;
      m_edge  <= 0;
      m_an    <= '1;
      m_seg   <= 7'b1111111;
    end else begin
      int dsel;
      dsel = (m_edge / SDIV) % ND;
      m_an   <= ~(ND'(1) << dsel);
      m_seg  <= m_ovf ? 7'b1111110 : seg_of((m_count / pow10(dsel)) % 10);
      m_edge <= m_edge + 1;
      if (load)    m_count <= load_dec(load_val);
      else if (ce) m_count <= up ? (m_count + 1) % (MAXV + 1) : (m_count + MAXV) % (MAXV + 1);
      if (model_tc())   m_ovf <= 1'b1;
      else if (clr_ovf) m_ovf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("count", 32'(count), 32'(to_bcd(m_count)));
    check("tc",    32'(tc),    32'(model_tc()));
    check("ovf",   32'(ovf),   32'(m_ovf));
    check("an",    32'(an),    32'(m_an));
    check("seg",   32'(seg),   32'(m_seg));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [ND-1:0] scan_pat [12] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD,
                                   4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7};

  initial begin
    // Reset
    tick(2);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf",   32'(ovf),   32'h0);
    check("rst_an",    32'(an),    32'hF);
    check("rst_seg",   32'(seg),   32'h7F);
    rst_n = 1'b1;
    tick(1);
    check("first_an",  32'(an),  32'hE);
    check("first_seg", 32'(seg), 32'b0000001);

    // Count up
    ce = 1; up = 1;
    tick(12);
    check("up12", 32'(count), 32'h0012);
    ce = 0; load = 1; load_val = 16'h0099;
    tick(1);
    load = 0; ce = 1;
    tick(1);
    check("carry", 32'(count), 32'h0100);

    // Wrap / OVF
    ce = 0; load = 1; load_val = 16'h9999;
    tick(1);
    load = 0; ce = 1; up = 1;
    #1 check("tc_up", 32'(tc), 32'h1);
    tick(1);
    check("wrap_count", 32'(count), 32'h0000);
    check("wrap_ovf",   32'(ovf),   32'h1);
    ce = 0;
    tick(1);
    check("dash0", 32'(seg), 32'b1111110);
    tick(3);
    check("dash1", 32'(seg), 32'b1111110);
    clr_ovf = 1;
    tick(1);
    clr_ovf = 0;
    check("clr_ovf", 32'(ovf), 32'h0);
    tick(1);
    check("zero_seg", 32'(seg), 32'b0000001);

    // Down / borrow
    load = 1; load_val = 16'h1000;
    tick(1);
    load = 0; up = 0; ce = 1;
    tick(1);
    check("borrow", 32'(count), 32'h0999);
    ce = 0; load = 1; load_val = 16'h0000;
    tick(1);
    load = 0; ce = 1;
    tick(1);
    ce = 0;
    check("wrap_dn", 32'(count), 32'h9999);
    check("wrap_dn_ovf", 32'(ovf), 32'h1);

    // Priority / invalid nibble
    clr_ovf = 1;
    tick(1);
    clr_ovf = 0;
    load = 1; ce = 1; up = 1; load_val = 16'h12F4;
    tick(1);
    load = 0; ce = 0;
    check("load_prio", 32'(count), 32'h1204);
    check("load_ovf",  32'(ovf),   32'h0);

    // Wrap and clear in the same cycle: set wins
    load = 1; load_val = 16'h0000;
    tick(1);
    load = 0; ce = 1; up = 0; clr_ovf = 1;
    tick(1);
    ce = 0; clr_ovf = 0;
    check("set_wins", 32'(ovf), 32'h1);

    // Async reset mid-scan, then scan sequence
    rst_n = 0;
    #1 check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    tick(1);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("scan_an", 32'(an), 32'(scan_pat[k]));
    end
    check("scan_seg", 32'(seg), 32'b0000001);

    // Randomized
    for (int it = 0; it < 600; it++) begin
      tick(1);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 0;
        #1 check("rnd_async_an", 32'(an), 32'hF);
        tick(1);
        rst_n = 1;
      end
      ce      = ($urandom_range(0, 3) != 0);
      up      = $urandom_range(0, 1) != 0;
      load    = ($urandom_range(0, 9) == 0);
      clr_ovf = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < ND; i++) begin
        load_val[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'(9 * $urandom_range(0, 1))
                                                         : 4'($urandom_range(0, 11));
      end
    end
    ce = 0; load = 0; clr_ovf = 0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
